quan_sched: RTL and testbench

QUAN_SCHED -- requirements
Module: quan_sched

---
 rtl/quan_sched.sv | 94 +++++++++
 tb/tb_quan_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quan_sched.sv
// quan_sched: feeds accumulator words to an external quantizer with per-channel
// parameters and returns the quantized results tagged with their channel.
module quan_sched #(
    parameter int NUM_CH_MAX = 16,
    parameter int QUAN_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [27:0] cfg_data,
    input  logic        start,
    input  logic [4:0]  num_ch,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [17:0] din,
    input  logic        din_last,
    output logic [17:0] q_din,
    output logic [15:0] q_scale_M0,
    output logic [3:0]  q_shift,
    output logic [7:0]  q_zero_point,
    input  logic [7:0]  q_dout,
    output logic        dout_valid,
    output logic [7:0]  dout,
    output logic [3:0]  dout_ch,
    output logic        busy,
    output logic        done
);
    localparam logic [4:0] CH_MAX = 5'(NUM_CH_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nx;
    logic [27:0] par_tbl [NUM_CH_MAX];
    logic [4:0]  num_ch_r;
    logic [3:0]  ch_cnt;
    logic [QUAN_LAT:0] vld_sr;
    logic [3:0]  tag_sr [QUAN_LAT+1];
    logic        xfer;

    assign din_ready = state == RUN;
    assign xfer      = din_valid & din_ready;
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = (xfer && din_last) ? DRAIN : RUN;
            DRAIN:   state_nx = (vld_sr == '0) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // parameter table has no reset; software loads it while idle
    always_ff @(posedge clk)
        if (cfg_we && state == IDLE) par_tbl[cfg_addr] <= cfg_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            num_ch_r     <= CH_MAX;
            ch_cnt       <= '0;
            vld_sr       <= '0;
            for (int i = 0; i <= QUAN_LAT; i++) tag_sr[i] <= '0;
            q_din        <= '0;
            q_scale_M0   <= '0;
            q_shift      <= '0;
            q_zero_point <= '0;
            dout_valid   <= 1'b0;
            dout         <= '0;
            dout_ch      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                num_ch_r <= (num_ch == '0 || num_ch > CH_MAX) ? CH_MAX : num_ch;
                ch_cnt   <= '0;
            end
            if (xfer) begin
                ch_cnt <= ({1'b0, ch_cnt} == num_ch_r - 5'd1) ? '0 : ch_cnt + 4'd1;
                q_din  <= din;
                {q_scale_M0, q_shift, q_zero_point} <= par_tbl[ch_cnt];
            end
            // tag pipeline mirrors the quantizer latency plus the output register
            vld_sr    <= {vld_sr[QUAN_LAT-1:0], xfer};
            tag_sr[0] <= ch_cnt;
            for (int i = 1; i <= QUAN_LAT; i++) tag_sr[i] <= tag_sr[i-1];
            dout_valid <= vld_sr[QUAN_LAT];
            dout       <= vld_sr[QUAN_LAT] ? q_dout : dout;
            dout_ch    <= vld_sr[QUAN_LAT] ? tag_sr[QUAN_LAT] : dout_ch;
        end
    end
endmodule

// File: tb/tb_quan_sched.sv
// tb_quan_sched: randomized layers against a transfer-level reference model,
// with a QUAN_LAT-deep behavioural quantizer standing in for module_quan.
module tb_quan_sched;
    localparam int QL  = 2;
    localparam int NCH = 16;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        logic [3:0] ch;
    } res_t;

    logic        clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, start = 1'b0;
    logic        din_valid = 1'b0, din_last = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [27:0] cfg_data = '0;
    logic [4:0]  num_ch = '0;
    logic [17:0] din = '0;
    logic        din_ready, dout_valid, busy, done;
    logic [17:0] q_din;
    logic [15:0] q_scale_M0;
    logic [3:0]  q_shift, dout_ch;
    logic [7:0]  q_zero_point, q_dout, dout;
    logic [7:0]  qp [QL];

    res_t        obs_q[$], exp_q[$];
    logic [27:0] tbl [NCH];
    logic [17:0] last_din;
    int          cyc = 0, eff, mch, last_xfer, fixed_din = -1;
    int          n_vec = 0, n_err = 0;

    quan_sched #(.NUM_CH_MAX(NCH), .QUAN_LAT(QL)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .num_ch(num_ch), .din_valid(din_valid), .din_ready(din_ready),
        .din(din), .din_last(din_last), .q_din(q_din), .q_scale_M0(q_scale_M0),
        .q_shift(q_shift), .q_zero_point(q_zero_point), .q_dout(q_dout),
        .dout_valid(dout_valid), .dout(dout), .dout_ch(dout_ch), .busy(busy), .done(done)
    );

    function automatic logic [7:0] qf(input logic [17:0] d, input logic [27:0] p);
        logic [33:0] m;
        m = 34'(d) * 34'(p[27:12]);
        return 8'((m >> p[11:8]) + 34'(p[7:0]));
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        qp[0] <= qf(q_din, {q_scale_M0, q_shift, q_zero_point});
        for (int i = 1; i < QL; i++) qp[i] <= qp[i-1];
    end
    assign q_dout = qp[QL-1];

    always @(negedge clk) if (dout_valid === 1'b1) obs_q.push_back('{cyc, dout, dout_ch});

    task automatic cfg_write(input logic [3:0] a, input logic [27:0] v, input bit in_idle);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = v;
        @(negedge clk);
        cfg_we = 1'b0;
        if (in_idle) tbl[a] = v;
    endtask

    task automatic start_layer(input int n);
        @(negedge clk);
        start = 1'b1; num_ch = 5'(n);
        eff = (n == 0 || n > NCH) ? NCH : n;
        mch = 0;
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_words(input int nw, input bit rnd, input bit with_last);
        int k = 0, guard = 0;
        while (k < nw && guard < 4000) begin
            din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            din       = fixed_din >= 0 ? 18'(fixed_din) : 18'($urandom);
            din_last  = with_last && (k == nw - 1);
            if (din_valid && din_ready) begin
                exp_q.push_back('{cyc + 1 + QL + 1, qf(din, tbl[mch]), 4'(mch)});
                last_xfer = cyc + 1;
                last_din  = din;
                mch       = (mch + 1) % eff;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        din_valid = 1'b0; din_last = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int dc);
        ok = 1'b0; dc = 0;
        for (int i = 0; i < 60 && !ok; i++)
            if (done === 1'b1) begin ok = 1'b1; dc = cyc; end
            else @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if ({din_ready, dout_valid, busy, done, dout, dout_ch, q_din, q_scale_M0, q_shift, q_zero_point} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b vld=%b busy=%b done=%b dout=%h ch=%h q_din=%h M0=%h sh=%h zp=%h, expected all zero",
                     din_ready, dout_valid, busy, done, dout, dout_ch, q_din, q_scale_M0, q_shift, q_zero_point);
        end
        rst_n = 1'b1;
        for (int i = 1; i < NCH; i++) cfg_write(4'(i), 28'($urandom), 1'b1);
    endtask

    task automatic test_basic;
        bit ok; int dc;
        cfg_write(4'd0, {16'd1, 4'd5, 8'd1}, 1'b1);
        fixed_din = 'h2EBC2;
        start_layer(1);
        send_words(1, 1'b0, 1'b1);
        fixed_din = -1;
        n_vec++;
        if ({q_scale_M0, q_shift, q_zero_point, q_din} !== {16'd1, 4'd5, 8'd1, 18'h2EBC2}) begin
            n_err++;
            $display("FAIL basic_qregs: got M0=%h sh=%h zp=%h din=%h, expected 1 5 1 2ebc2", q_scale_M0, q_shift, q_zero_point, q_din);
        end
        n_vec++;
        if (din_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_drop: got %b, expected 0", din_ready); end
        wait_done(ok, dc);
        n_vec++;
        if (!ok || obs_q.size() != 1) begin
            n_err++; $display("FAIL basic_done: done_seen=%b results=%0d, expected 1 and 1", ok, obs_q.size());
        end else begin
            n_vec++;
            if (obs_q[0].cyc != last_xfer + QL + 1 || obs_q[0].val !== exp_q[0].val || obs_q[0].ch !== 4'd0 || dc <= obs_q[0].cyc) begin
                n_err++;
                $display("FAIL basic_result: got cyc=%0d val=%h ch=%0d done@%0d, expected cyc=%0d val=%h ch=0 done later",
                         obs_q[0].cyc, obs_q[0].val, obs_q[0].ch, dc, last_xfer + QL + 1, exp_q[0].val);
            end
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || q_din !== 18'h2EBC2) begin
            n_err++; $display("FAIL basic_idle_hold: got busy=%b q_din=%h, expected 0 2ebc2", busy, q_din);
        end
    endtask

    task automatic test_wrap3;
        bit ok; int dc;
        start_layer(3);
        send_words(7, 1'b0, 1'b1);
        wait_done(ok, dc);
        n_vec++;
        if (!ok || obs_q.size() != 7) begin
            n_err++; $display("FAIL wrap3_count: done_seen=%b results=%0d, expected 1 and 7", ok, obs_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_vec++;
                if (obs_q[i].ch !== 4'(i % 3) || obs_q[i].cyc != obs_q[0].cyc + i || obs_q[i].val !== exp_q[i].val) begin
                    n_err++;
                    $display("FAIL wrap3_item%0d: got ch=%0d cyc=%0d val=%h, expected ch=%0d cyc=%0d val=%h",
                             i, obs_q[i].ch, obs_q[i].cyc, obs_q[i].val, i % 3, obs_q[0].cyc + i, exp_q[i].val);
                end
            end
        end
    endtask

    task automatic test_random_valid;
        bit ok; int dc;
        start_layer($urandom_range(1, NCH));
        send_words(10, 1'b1, 1'b1);
        wait_done(ok, dc);
        n_vec++;
        if (!ok || obs_q.size() != 10 || exp_q.size() != 10 || dc <= obs_q[obs_q.size()-1].cyc) begin
            n_err++; $display("FAIL randvalid_count: done_seen=%b results=%0d sent=%0d done@%0d, expected 10 results then done", ok, obs_q.size(), exp_q.size(), dc);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_vec++;
                if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].val !== exp_q[i].val || obs_q[i].ch !== exp_q[i].ch) begin
                    n_err++;
                    $display("FAIL randvalid_item%0d: got cyc=%0d val=%h ch=%0d, expected cyc=%0d val=%h ch=%0d",
                             i, obs_q[i].cyc, obs_q[i].val, obs_q[i].ch, exp_q[i].cyc, exp_q[i].val, exp_q[i].ch);
                end
            end
        end
    endtask

    task automatic test_cfg_in_run;
        bit ok; int dc;
        start_layer(3);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = ~tbl[2];
        start = 1'b1; num_ch = 5'd7;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        send_words(9, 1'b0, 1'b1);
        wait_done(ok, dc);
        n_vec++;
        if (!ok || obs_q.size() != 9) begin
            n_err++; $display("FAIL cfgrun_count: done_seen=%b results=%0d, expected 1 and 9", ok, obs_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_vec++;
                if (obs_q[i].val !== exp_q[i].val || obs_q[i].ch !== exp_q[i].ch) begin
                    n_err++;
                    $display("FAIL cfgrun_item%0d: got val=%h ch=%0d, expected val=%h ch=%0d", i, obs_q[i].val, obs_q[i].ch, exp_q[i].val, exp_q[i].ch);
                end
            end
        end
    endtask

    task automatic test_start_cfg;
        bit ok; int dc;
        @(negedge clk);
        start = 1'b1; num_ch = 5'd2; cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 28'($urandom);
        tbl[1] = cfg_data; eff = 2; mch = 0;
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        send_words(4, 1'b0, 1'b1);
        wait_done(ok, dc);
        n_vec++;
        if (!ok || obs_q.size() != 4) begin
            n_err++; $display("FAIL startcfg_count: done_seen=%b results=%0d, expected 1 and 4", ok, obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs_q[i].val !== exp_q[i].val || obs_q[i].ch !== exp_q[i].ch) begin
                    n_err++;
                    $display("FAIL startcfg_item%0d: got val=%h ch=%0d, expected val=%h ch=%0d", i, obs_q[i].val, obs_q[i].ch, exp_q[i].val, exp_q[i].ch);
                end
            end
        end
    endtask

    task automatic test_reset_midlayer;
        bit ok; int dc;
        start_layer(4);
        send_words(2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, din_ready, dout_valid} !== 3'b000) begin
            n_err++; $display("FAIL midreset_async: got busy=%b ready=%b vld=%b, expected 000", busy, din_ready, dout_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_vec++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midreset_flush: got %0d results busy=%b, expected 0 results busy=0", obs_q.size(), busy);
        end
        start_layer(2);
        send_words(3, 1'b0, 1'b1);
        wait_done(ok, dc);
        n_vec++;
        if (!ok || obs_q.size() != 3) begin
            n_err++; $display("FAIL midreset_restart: done_seen=%b results=%0d, expected 1 and 3", ok, obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].val !== exp_q[i].val || obs_q[i].ch !== exp_q[i].ch) begin
                    n_err++;
                    $display("FAIL midreset_item%0d: got cyc=%0d val=%h ch=%0d, expected cyc=%0d val=%h ch=%0d",
                             i, obs_q[i].cyc, obs_q[i].val, obs_q[i].ch, exp_q[i].cyc, exp_q[i].val, exp_q[i].ch);
                end
            end
        end
    endtask

    task automatic test_num_ch0;
        bit ok; int dc;
        start_layer(0);
        send_words(20, 1'b0, 1'b1);
        wait_done(ok, dc);
        n_vec++;
        if (!ok || obs_q.size() != 20) begin
            n_err++; $display("FAIL numch0_count: done_seen=%b results=%0d, expected 1 and 20", ok, obs_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_vec++;
                if (obs_q[i].ch !== 4'(i % NCH) || obs_q[i].val !== exp_q[i].val) begin
                    n_err++;
                    $display("FAIL numch0_item%0d: got ch=%0d val=%h, expected ch=%0d val=%h", i, obs_q[i].ch, obs_q[i].val, i % NCH, exp_q[i].val);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok; int dc;
        for (int l = 0; l < 4; l++) begin
            start_layer($urandom_range(0, 20));
            send_words($urandom_range(1, 24), 1'($urandom_range(0, 1)), 1'b1);
            wait_done(ok, dc);
            n_vec++;
            if (!ok || obs_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL b2b_layer%0d_count: done_seen=%b results=%0d, expected 1 and %0d", l, ok, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_vec++;
                    if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].val !== exp_q[i].val || obs_q[i].ch !== exp_q[i].ch) begin
                        n_err++;
                        $display("FAIL b2b_layer%0d_item%0d: got cyc=%0d val=%h ch=%0d, expected cyc=%0d val=%h ch=%0d",
                                 l, i, obs_q[i].cyc, obs_q[i].val, obs_q[i].ch, exp_q[i].cyc, exp_q[i].val, exp_q[i].ch);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap3;
        test_random_valid;
        test_cfg_in_run;
        test_start_cfg;
        test_reset_midlayer;
        test_num_ch0;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
